// File: rtl/remap_pkg.sv
// Shared types and default constants for the remap line scheduler.
// Optional statistics counters are enabled by defining REMAP_SCHED_STATS_EN.
package remap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        REQ  = 2'd2,
        BUSY = 2'd3
    } sched_state_t;

    localparam logic [15:0] VID_VACT_DEF     = 16'd720;
    localparam logic [15:0] LINE_TIMEOUT_DEF = 16'd8191;
    localparam int          IDX_W_DEF        = 12;

endpackage

// File: rtl/remap_line_sched_if.sv
// Handshake bundle between the line scheduler (master) and the
// L/R remap engines plus output stage (slave).
interface remap_line_sched_if
    import remap_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) ();

    logic             rmp_out_ready;
    logic             rmp_L_in_fifo_full;
    logic             rmp_R_in_fifo_full;
    logic             rmp_L_read_ack;
    logic             rmp_R_read_ack;
    logic             rmp_L_line_done;
    logic             rmp_R_line_done;
    logic             rmp_L_read_req;
    logic             rmp_R_read_req;
    logic [IDX_W-1:0] rmp_line_idx;

    modport master (
        input  rmp_out_ready,
        input  rmp_L_in_fifo_full,
        input  rmp_R_in_fifo_full,
        input  rmp_L_read_ack,
        input  rmp_R_read_ack,
        input  rmp_L_line_done,
        input  rmp_R_line_done,
        output rmp_L_read_req,
        output rmp_R_read_req,
        output rmp_line_idx
    );

    modport slave (
        output rmp_out_ready,
        output rmp_L_in_fifo_full,
        output rmp_R_in_fifo_full,
        output rmp_L_read_ack,
        output rmp_R_read_ack,
        output rmp_L_line_done,
        output rmp_R_line_done,
        input  rmp_L_read_req,
        input  rmp_R_read_req,
        input  rmp_line_idx
    );

endinterface

// File: rtl/remap_pair_handshake.sv
// One side (L or R) of the paired engine handshake: holds the read
// request until acked and keeps sticky ack/done flags for the line.
// The *_now outputs fold in a same-cycle pulse so the scheduler can
// advance without waiting an extra cycle for the flag to register.
module remap_pair_handshake (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic clear,
    input  logic ack_en,
    input  logic done_en,
    input  logic ack,
    input  logic done,
    output logic req,
    output logic acked_now,
    output logic done_now
);

    logic acked;
    logic done_seen;

    // Request/flag tracking; clear (abort or line finished) beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            req       <= 1'b0;
            acked     <= 1'b0;
            done_seen <= 1'b0;
        end else if (clear) begin
            req       <= 1'b0;
            acked     <= 1'b0;
            done_seen <= 1'b0;
        end else if (issue) begin
            req       <= 1'b1;
            acked     <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (ack_en && ack) begin
                acked <= 1'b1;
                req   <= 1'b0;
            end
            if (done_en && done) begin
                done_seen <= 1'b1;
            end
        end
    end

    assign acked_now = acked | (ack_en & ack);
    assign done_now  = done_seen | (done_en & done);

endmodule

// File: rtl/remap_line_sched.sv
// Line scheduler for the L/R remap engines. Starts a frame on the VS
// rising edge, issues paired line requests when the output stage has a
// slot, and tracks completion, timeouts and VS aborts.
// Optional stall/line statistics are enabled by REMAP_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | no frame in progress, waiting for VS edge
// SLOT  | waiting for output stage ready and both FIFOs below prog_full
// REQ   | paired requests outstanding, waiting for both acks
// BUSY  | both engines processing, waiting for both line_done
module remap_line_sched
    import remap_pkg::*;
#(
    parameter logic [15:0] VID_VACT     = VID_VACT_DEF,
    parameter logic [15:0] LINE_TIMEOUT = LINE_TIMEOUT_DEF,
    parameter int          IDX_W        = IDX_W_DEF
) (
    input  logic                      mpt_clk,
    input  logic                      mpt_arst,
    input  logic                      vid_vs_in,
    remap_line_sched_if.master        rmp,
    output logic                      frame_active,
    output logic                      frame_done,
    output logic                      sched_err
`ifdef REMAP_SCHED_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               line_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VID_VACT - 16'd1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    sched_state_t     state;
    logic             vs_1d;
    logic [15:0]      tcnt;
    logic [IDX_W-1:0] line_idx;

    logic vs_edge;
    logic busy_st;
    logic timeout;
    logic abort_vs;
    logic go_req;
    logic line_fin;
    logic hs_clear;
    logic ack_en;
    logic acked_l, acked_r;
    logic done_l, done_r;
    logic req_l, req_r;

    // Decisions shared by the FSM and both handshake trackers.
    always_comb begin
        vs_edge  = vid_vs_in & ~vs_1d;
        busy_st  = (state == REQ) || (state == BUSY);
        timeout  = busy_st && (tcnt == LINE_TIMEOUT);
        abort_vs = vs_edge && (state != IDLE);
        go_req   = (state == SLOT) && rmp.rmp_out_ready
                   && !rmp.rmp_L_in_fifo_full && !rmp.rmp_R_in_fifo_full
                   && !vs_edge;
        line_fin = (state == BUSY) && done_l && done_r && !abort_vs && !timeout;
        hs_clear = abort_vs || timeout || line_fin;
        ack_en   = (state == REQ);
    end

    remap_pair_handshake u_hs_l (
        .clk       (mpt_clk),
        .rst       (mpt_arst),
        .issue     (go_req),
        .clear     (hs_clear),
        .ack_en    (ack_en),
        .done_en   (busy_st),
        .ack       (rmp.rmp_L_read_ack),
        .done      (rmp.rmp_L_line_done),
        .req       (req_l),
        .acked_now (acked_l),
        .done_now  (done_l)
    );

    remap_pair_handshake u_hs_r (
        .clk       (mpt_clk),
        .rst       (mpt_arst),
        .issue     (go_req),
        .clear     (hs_clear),
        .ack_en    (ack_en),
        .done_en   (busy_st),
        .ack       (rmp.rmp_R_read_ack),
        .done      (rmp.rmp_R_line_done),
        .req       (req_r),
        .acked_now (acked_r),
        .done_now  (done_r)
    );

    assign rmp.rmp_L_read_req = req_l;
    assign rmp.rmp_R_read_req = req_r;
    assign rmp.rmp_line_idx   = line_idx;

    // Frame/line FSM with timeout counter; VS abort outranks timeout so a
    // coincident pair yields a single error pulse and a restart.
    always_ff @(posedge mpt_clk) begin
        if (mpt_arst) begin
            state        <= IDLE;
            vs_1d        <= 1'b0;
            tcnt         <= 16'd0;
            line_idx     <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            sched_err    <= 1'b0;
        end else begin
            vs_1d      <= vid_vs_in;
            frame_done <= 1'b0;
            sched_err  <= 1'b0;
            if (busy_st && (tcnt != 16'hFFFF)) begin
                tcnt <= tcnt + 16'd1;
            end
            if (abort_vs) begin
                sched_err    <= 1'b1;
                line_idx     <= '0;
                frame_active <= 1'b1;
                state        <= SLOT;
            end else if (timeout) begin
                sched_err    <= 1'b1;
                frame_active <= 1'b0;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (vs_edge) begin
                            line_idx     <= '0;
                            frame_active <= 1'b1;
                            state        <= SLOT;
                        end
                    end
                    SLOT: begin
                        if (go_req) begin
                            tcnt  <= 16'd0;
                            state <= REQ;
                        end
                    end
                    REQ: begin
                        if (acked_l && acked_r) begin
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (line_fin) begin
                            if (line_idx == LAST_IDX) begin
                                frame_done   <= 1'b1;
                                frame_active <= 1'b0;
                                line_idx     <= '0;
                                state        <= IDLE;
                            end else begin
                                line_idx <= line_idx + IDX_ONE;
                                state    <= SLOT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef REMAP_SCHED_STATS_EN
    // Saturating stall and completed-line counters, cleared only by reset.
    always_ff @(posedge mpt_clk) begin
        if (mpt_arst) begin
            stall_cnt <= 32'd0;
            line_cnt  <= 32'd0;
        end else begin
            if ((state == SLOT) && rmp.rmp_out_ready
                && (rmp.rmp_L_in_fifo_full || rmp.rmp_R_in_fifo_full)
                && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (line_fin && (line_cnt != 32'hFFFF_FFFF)) begin
                line_cnt <= line_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
